seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_glyph_rom.sv | 12 +
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg_pkg;

    // Active-high glyphs, bit0=a .. bit6=g, indexed by hex nibble.
    localparam logic [6:0] GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam int         MIN_SLOT = 2;

    // Position inside a digit slot: the first cycle is a dark guard cycle.
    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/seg_glyph_rom.sv
// Hex nibble to active-high gfedcba glyph lookup.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    // Pure table lookup, no state.
    always_comb glyph_o = GLYPH[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-scanned NDIG-digit common-anode 7-segment driver with guard cycles,
// leading-zero suppression and a double-buffered display value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int DIV_W       = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4*NDIG-1:0] VALUE,
    input  logic [NDIG-1:0]   DP,
    input  logic [NDIG-1:0]   BLANK,
    input  logic              LOAD,
    input  logic              LZ_EN,
    input  logic [DIV_W-1:0]  DIV,
    output logic [6:0]        SEG,
    output logic              SEG_DP,
    output logic [NDIG-1:0]   AN,
    output logic              FRAME
);

    localparam int               IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIV_W-1:0] MIN_LEN  = DIV_W'(MIN_SLOT);
    localparam logic [DIV_W-1:0] ONE_D    = DIV_W'(1);
    localparam logic [IDX_W-1:0] ONE_I    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    // Pin-polarity helpers: everything inside is active-high.
    function automatic logic [6:0] seg_pin(input logic [6:0] s);
        return (SEG_ACT_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic dp_pin(input logic d);
        return (SEG_ACT_LOW != 0) ? ~d : d;
    endfunction

    function automatic logic [NDIG-1:0] an_pin(input logic [NDIG-1:0] a);
        return (AN_ACT_LOW != 0) ? ~a : a;
    endfunction

    logic [DIV_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [NDIG-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic              pend_flag_q, pend_flag_d;
    logic [6:0]        seg_q, seg_d;
    logic              seg_dp_q, seg_dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_q, frame_d;

    phase_e            phase_d;
    logic              swap, run, lit, show_dp, dp_sel, blank_sel, supp_sel;
    logic [NDIG-1:0]   supp, onehot;
    logic [3:0]        nib_sel;
    logic [6:0]        glyph;

    seg_glyph_rom u_rom (
        .nib_i   (nib_sel),
        .glyph_o (glyph)
    );

    // Next scan position, buffer transfer and the outputs for the coming cycle.
    // Outputs are computed from the next position so they land in the cycle
    // they describe.
    always_comb begin
        // DIV is only looked at in the guard cycle; the slot keeps that length.
        len_d = (cnt_q == '0) ? ((DIV < MIN_LEN) ? MIN_LEN : DIV) : len_q;
        if (cnt_q == len_d - ONE_D) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ONE_I;
        end else begin
            cnt_d = cnt_q + ONE_D;
            idx_d = idx_q;
        end
        phase_d = (cnt_d == '0) ? PH_GUARD : PH_DRIVE;
        frame_d = (idx_d == LAST_IDX) && (cnt_d == len_d - ONE_D);

        // A LOAD in the frame cycle itself goes straight through to active.
        swap         = frame_q && (pend_flag_q || LOAD);
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_flag_d  = pend_flag_q;
        if (LOAD) begin
            pend_val_d   = VALUE;
            pend_dp_d    = DP;
            pend_blank_d = BLANK;
            pend_flag_d  = 1'b1;
        end
        if (swap) begin
            pend_flag_d = 1'b0;
        end
        act_val_d   = swap ? pend_val_d   : act_val_q;
        act_dp_d    = swap ? pend_dp_d    : act_dp_q;
        act_blank_d = swap ? pend_blank_d : act_blank_q;

        // Suppression walks down from the top digit; a nonzero nibble or a
        // requested DP stops it. Digit 0 is always shown.
        run  = 1'b1;
        supp = '0;
        for (int k = NDIG - 1; k > 0; k--) begin
            run     = run && (act_val_d[4*k +: 4] == 4'h0) && !act_dp_d[k];
            supp[k] = LZ_EN && run;
        end

        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        supp_sel  = 1'b0;
        onehot    = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib_sel   = act_val_d[4*k +: 4];
                dp_sel    = act_dp_d[k];
                blank_sel = act_blank_d[k];
                supp_sel  = supp[k];
                onehot[k] = 1'b1;
            end
        end

        lit     = (phase_d == PH_DRIVE) && !blank_sel && !supp_sel;
        show_dp = (phase_d == PH_DRIVE) && !blank_sel && dp_sel;
        seg_d    = seg_pin(lit ? glyph : SEG_OFF);
        seg_dp_d = dp_pin(show_dp);
        an_d     = an_pin((lit || show_dp) ? onehot : '0);
    end

    // State and output registers; reset darkens the display and drops both buffers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            len_q        <= MIN_LEN;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_flag_q  <= 1'b0;
            seg_q        <= seg_pin(SEG_OFF);
            seg_dp_q     <= dp_pin(1'b0);
            an_q         <= an_pin('0);
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_flag_q  <= pend_flag_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign SEG    = seg_q;
    assign SEG_DP = seg_dp_q;
    assign AN     = an_q;
    assign FRAME  = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-cycle expected pin values are queued from
// hand-derived glyph/timing tables and compared as the display scans.
module tb_seg_scan_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] VALUE;
    logic [3:0]  DP, BLANK;
    logic        LOAD, LZ_EN;
    logic [15:0] DIV;
    logic [6:0]  SEG;
    logic        SEG_DP;
    logic [3:0]  AN;
    logic        FRAME;

    seg_scan_driver #(.NDIG(4), .DIV_W(16), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .VALUE  (VALUE),
        .DP     (DP),
        .BLANK  (BLANK),
        .LOAD   (LOAD),
        .LZ_EN  (LZ_EN),
        .DIV    (DIV),
        .SEG    (SEG),
        .SEG_DP (SEG_DP),
        .AN     (AN),
        .FRAME  (FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    // Pin values (active-low) of the glyphs used below.
    localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30;
    localparam logic [6:0] P4 = 7'h19, P5 = 7'h12, PA = 7'h08, PF = 7'h0E;
    localparam logic [6:0] POFF = 7'h7F;
    localparam logic [27:0] ZEROS = {P0, P0, P0, P0};

    function automatic exp_t mk(input logic [3:0] an, input logic [6:0] seg,
                                input logic dp, input logic fr);
        exp_t r;
        r.an = an; r.seg = seg; r.dp = dp; r.fr = fr;
        return r;
    endfunction

    task automatic push_idle();
        sb.push_back(mk(4'hF, POFF, 1'b1, 1'b0));
    endtask

    // One slot: dark guard cycle, then L-1 cycles of digit s.
    task automatic push_slot(input int s, input int L, input logic [6:0] seg_pin,
                             input logic on, input logic dp_on);
        logic [3:0] an;
        push_idle();
        for (int c = 1; c < L; c++) begin
            an = 4'hF;
            if (on) an[s] = 1'b0;
            sb.push_back(mk(an, on ? seg_pin : POFF, ~dp_on, (s == 3) && (c == L - 1)));
        end
    endtask

    task automatic push_frame(input int L, input logic [27:0] segs,
                              input logic [3:0] on, input logic [3:0] dpm);
        for (int s = 0; s < 4; s++) push_slot(s, L, segs[s*7 +: 7], on[s], dpm[s]);
    endtask

    task automatic do_reset();
        RST = 1'b1; LOAD = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        RST = 1'b1; LOAD = 1'b1; VALUE = 16'hFFFF; DP = 4'hF; BLANK = 4'h0;
        LZ_EN = 1'b0; DIV = 16'd4;
        @(posedge CLK); #1;
        repeat (3) push_idle();
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_frame(4, ZEROS, 4'hF, 4'h0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            RST  = (i < 3);
            LOAD = (i < 3);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL reset i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_decode();
        int n;
        VALUE = 16'h1A3F; DP = 4'h0; BLANK = 4'h0; LZ_EN = 1'b0; DIV = 16'd4;
        do_reset();
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_frame(4, {P1, PA, P3, PF}, 4'hF, 4'h0);
        push_frame(4, {P1, PA, P3, PF}, 4'hF, 4'h0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            LOAD = (i == 0);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL decode i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_lz();
        int n;
        VALUE = 16'h0050; DP = 4'h0; BLANK = 4'h0; LZ_EN = 1'b1; DIV = 16'd4;
        do_reset();
        push_frame(4, ZEROS, 4'b0001, 4'h0);
        push_frame(4, {POFF, POFF, P5, P0}, 4'b0011, 4'h0);
        push_frame(4, ZEROS, 4'b0001, 4'h0);
        push_frame(4, ZEROS, 4'b0011, 4'b0010);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 16) begin VALUE = 16'h0000; DP = 4'b0000; end
            if (i == 32) begin VALUE = 16'h0000; DP = 4'b0010; end
            LOAD = (i == 0) || (i == 16) || (i == 32);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL lz i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_blank_dp();
        int n;
        VALUE = 16'h1234; DP = 4'b0101; BLANK = 4'b0100; LZ_EN = 1'b0; DIV = 16'd4;
        do_reset();
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_frame(4, {P1, POFF, P3, P4}, 4'b1011, 4'b0001);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            LOAD = (i == 0);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL blank_dp i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        VALUE = 16'h0000; DP = 4'h0; BLANK = 4'h0; LZ_EN = 1'b0; DIV = 16'd4;
        do_reset();
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_frame(4, {P2, P2, P2, P2}, 4'hF, 4'h0);
        push_frame(4, {P3, P3, P3, P3}, 4'hF, 4'h0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 5)  VALUE = 16'h1111;
            if (i == 9)  VALUE = 16'h2222;
            if (i == 31) VALUE = 16'h3333;
            LOAD = (i == 5) || (i == 9) || (i == 31);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL back_to_back i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_div();
        int n;
        VALUE = 16'h0000; DP = 4'h0; BLANK = 4'h0; LZ_EN = 1'b0; DIV = 16'd0;
        do_reset();
        push_frame(2, ZEROS, 4'hF, 4'h0);
        push_frame(2, ZEROS, 4'hF, 4'h0);
        push_slot(0, 4, P0, 1'b1, 1'b0);
        push_slot(1, 8, P0, 1'b1, 1'b0);
        push_slot(2, 8, P0, 1'b1, 1'b0);
        push_slot(3, 8, P0, 1'b1, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 8)  DIV = 16'd1;
            if (i == 16) DIV = 16'd4;
            if (i == 17) DIV = 16'd8;
            LOAD = 1'b0;
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL div i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        VALUE = 16'h1A3F; DP = 4'h0; BLANK = 4'h0; LZ_EN = 1'b0; DIV = 16'd4;
        do_reset();
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_slot(0, 4, PF, 1'b1, 1'b0);
        push_slot(1, 4, P3, 1'b1, 1'b0);
        push_idle();
        sb.push_back(mk(4'hB, PA, 1'b1, 1'b0));
        push_frame(4, ZEROS, 4'hF, 4'h0);
        push_frame(4, ZEROS, 4'hF, 4'h0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 20) VALUE = 16'h5555;
            LOAD = (i == 0) || (i == 20);
            RST  = (i == 25);
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, SEG_DP, FRAME} !== e) begin
                failures++;
                $display("FAIL reset_mid i=%0d got AN=%h SEG=%h DP=%b FR=%b want AN=%h SEG=%h DP=%b FR=%b",
                         i, AN, SEG, SEG_DP, FRAME, e.an, e.seg, e.dp, e.fr);
            end
            @(posedge CLK); #1;
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; LOAD = 1'b0; VALUE = '0; DP = '0; BLANK = '0; LZ_EN = 1'b0; DIV = 16'd4;
        test_reset();
        test_decode();
        test_lz();
        test_blank_dp();
        test_back_to_back();
        test_div();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
